// File: rtl/cd_rx_frame_ctrl.sv
// cd_rx_frame_ctrl: CDBUS receive-side frame controller.
// Takes the deserialized byte stream and filters frames on destination address.
// Checks the length and CRC of each frame and writes accepted bytes into one of
// two 256-byte RX pages. Completed pages are handed to the host through a
// valid/release handshake. Every output is registered.
`timescale 1ns/1ps

module cd_rx_frame_ctrl (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        bus_idle,
  input  logic        rx_break,
  input  logic [7:0]  data,
  input  logic        data_clk,
  input  logic [15:0] crc_data,
  input  logic [7:0]  filter,
  input  logic        promisc,
  output logic        force_wait_idle,
  output logic        wr_en,
  output logic        wr_page,
  output logic [7:0]  wr_addr,
  output logic [7:0]  wr_data,
  output logic [1:0]  page_valid,
  output logic        rd_page,
  input  logic        page_release,
  output logic        frame_done,
  output logic        err_crc,
  output logic        err_frame,
  output logic        err_lost,
  output logic        err_break
);

  typedef enum logic [1:0] {
    WAIT_IDLE  = 2'd0,
    WAIT_START = 2'd1,
    RECV       = 2'd2,
    DROP       = 2'd3
  } state_t;

  // Largest payload that still fits a 256-byte page after the 3-byte header.
  localparam logic [7:0] MAX_LEN = 8'd253;

  state_t      state_r, state_s;
  logic [8:0]  byte_cnt_r, byte_cnt_s;
  logic [7:0]  len_r, len_s;
  logic [8:0]  len_ext_s;

  logic        wr_en_s;
  logic [7:0]  wr_addr_s;
  logic [7:0]  wr_data_s;
  logic        commit_s;
  logic        err_crc_s;
  logic        err_frame_s;
  logic        err_lost_s;
  logic        err_break_s;
  logic        fwi_s;

  logic        wr_page_s;
  logic        rd_page_s;
  logic [1:0]  page_valid_s;
  logic        release_ok_s;

  // Destination acceptance: promiscuous mode, exact match, or broadcast.
  function automatic logic addr_match(input logic [7:0] dst,
                                      input logic [7:0] local_addr,
                                      input logic       any_dst);
    return any_dst || (dst == local_addr) || (dst == 8'hff);
  endfunction

  assign len_ext_s = {1'b0, len_r};

  // Frame FSM: next state, byte counter and per-byte write/error decisions.
  always_comb begin
    state_s     = state_r;
    byte_cnt_s  = byte_cnt_r;
    len_s       = len_r;
    wr_en_s     = 1'b0;
    wr_addr_s   = wr_addr;
    wr_data_s   = wr_data;
    commit_s    = 1'b0;
    err_crc_s   = 1'b0;
    err_frame_s = 1'b0;
    err_lost_s  = 1'b0;
    err_break_s = 1'b0;
    fwi_s       = 1'b0;

    case (state_r)
      WAIT_IDLE: begin
        if (bus_idle) begin
          state_s = WAIT_START;
        end else begin
          state_s = WAIT_IDLE;
        end
      end

      WAIT_START: begin
        if (data_clk) begin
          if (page_valid[wr_page]) begin
            // Host still owns the target page: the frame has nowhere to go.
            err_lost_s = 1'b1;
            state_s    = DROP;
          end else begin
            wr_en_s    = 1'b1;
            wr_addr_s  = 8'h00;
            wr_data_s  = data;
            byte_cnt_s = 9'd1;
            state_s    = RECV;
          end
        end else begin
          state_s = WAIT_START;
        end
      end

      RECV: begin
        if (rx_break) begin
          err_break_s = 1'b1;
          state_s     = WAIT_IDLE;
        end else if (data_clk) begin
          byte_cnt_s = byte_cnt_r + 9'd1;
          if (byte_cnt_r == len_ext_s + 9'd4) begin
            // Second CRC byte: running CRC over the whole frame must be zero.
            if (crc_data == 16'h0000) begin
              commit_s = 1'b1;
            end else begin
              err_crc_s = 1'b1;
              fwi_s     = 1'b1;
            end
            state_s = WAIT_IDLE;
          end else if (byte_cnt_r == 9'd1) begin
            if (addr_match(data, filter, promisc)) begin
              wr_en_s   = 1'b1;
              wr_addr_s = byte_cnt_r[7:0];
              wr_data_s = data;
            end else begin
              // Not for us: drop quietly, the bus stays usable for others.
              state_s = DROP;
            end
          end else if (byte_cnt_r == 9'd2) begin
            if (data > MAX_LEN) begin
              err_frame_s = 1'b1;
              fwi_s       = 1'b1;
              state_s     = DROP;
            end else begin
              len_s     = data;
              wr_en_s   = 1'b1;
              wr_addr_s = byte_cnt_r[7:0];
              wr_data_s = data;
            end
          end else if (byte_cnt_r <= len_ext_s + 9'd2) begin
            wr_en_s   = 1'b1;
            wr_addr_s = byte_cnt_r[7:0];
            wr_data_s = data;
          end else begin
            // First CRC byte: consumed but never stored.
            state_s = RECV;
          end
        end else if (bus_idle) begin
          // Line went idle before the frame was complete.
          err_frame_s = 1'b1;
          state_s     = WAIT_IDLE;
        end else begin
          state_s = RECV;
        end
      end

      DROP: begin
        if (bus_idle || rx_break) begin
          state_s = WAIT_IDLE;
        end else begin
          state_s = DROP;
        end
      end

      default: begin
        state_s = WAIT_IDLE;
      end
    endcase
  end

  // Page ownership: commits fill wr_page, host releases free rd_page.
  always_comb begin
    page_valid_s = page_valid;
    wr_page_s    = wr_page;
    rd_page_s    = rd_page;
    release_ok_s = page_release & page_valid[rd_page];

    if (release_ok_s) begin
      page_valid_s[rd_page] = 1'b0;
      rd_page_s             = ~rd_page;
    end else begin
      rd_page_s = rd_page;
    end

    // A commit only ever targets a page that was free at frame start, so it
    // never collides with the page being released in the same cycle.
    if (commit_s) begin
      page_valid_s[wr_page] = 1'b1;
      wr_page_s             = ~wr_page;
    end else begin
      wr_page_s = wr_page;
    end
  end

  // FSM state, byte counter and captured length.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_r    <= WAIT_IDLE;
      byte_cnt_r <= 9'd0;
      len_r      <= 8'd0;
    end else begin
      state_r    <= state_s;
      byte_cnt_r <= byte_cnt_s;
      len_r      <= len_s;
    end
  end

  // Registered buffer write port and status pulses.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_en           <= 1'b0;
      wr_addr         <= 8'h00;
      wr_data         <= 8'h00;
      frame_done      <= 1'b0;
      err_crc         <= 1'b0;
      err_frame       <= 1'b0;
      err_lost        <= 1'b0;
      err_break       <= 1'b0;
      force_wait_idle <= 1'b0;
    end else begin
      wr_en           <= wr_en_s;
      wr_addr         <= wr_addr_s;
      wr_data         <= wr_data_s;
      frame_done      <= commit_s;
      err_crc         <= err_crc_s;
      err_frame       <= err_frame_s;
      err_lost        <= err_lost_s;
      err_break       <= err_break_s;
      force_wait_idle <= fwi_s;
    end
  end

  // Page pointers and per-page valid flags.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_page    <= 1'b0;
      rd_page    <= 1'b0;
      page_valid <= 2'b00;
    end else begin
      wr_page    <= wr_page_s;
      rd_page    <= rd_page_s;
      page_valid <= page_valid_s;
    end
  end

endmodule

// File: tb/tb_cd_rx_frame_ctrl.sv
// tb_cd_rx_frame_ctrl: scoreboard bench for cd_rx_frame_ctrl.
// A frame-level reference model predicts the writes and pulses for each frame
// and queues them. A monitor compares them against the DUT outputs.
`timescale 1ns/1ps

module tb_cd_rx_frame_ctrl;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        bus_idle = 1'b1;
  logic        rx_break = 1'b0;
  logic [7:0]  data = 8'h00;
  logic        data_clk = 1'b0;
  logic [15:0] crc_data = 16'h0000;
  logic [7:0]  filter = 8'h05;
  logic        promisc = 1'b0;
  logic        page_release = 1'b0;
  logic        force_wait_idle, wr_en, wr_page, rd_page, frame_done;
  logic        err_crc, err_frame, err_lost, err_break;
  logic [7:0]  wr_addr, wr_data;
  logic [1:0]  page_valid;

  cd_rx_frame_ctrl dut (
    .clk(clk), .reset_n(reset_n), .bus_idle(bus_idle), .rx_break(rx_break),
    .data(data), .data_clk(data_clk), .crc_data(crc_data), .filter(filter),
    .promisc(promisc), .force_wait_idle(force_wait_idle), .wr_en(wr_en),
    .wr_page(wr_page), .wr_addr(wr_addr), .wr_data(wr_data),
    .page_valid(page_valid), .rd_page(rd_page), .page_release(page_release),
    .frame_done(frame_done), .err_crc(err_crc), .err_frame(err_frame),
    .err_lost(err_lost), .err_break(err_break)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic       wr;
    logic       pg;
    logic [7:0] addr;
    logic [7:0] dat;
    logic [5:0] fl;   // {frame_done, err_crc, err_frame, err_lost, err_break, force_wait_idle}
  } ev_t;
  typedef logic [7:0] bq_t[$];

  localparam logic [5:0] FL_DONE  = 6'b100000;
  localparam logic [5:0] FL_CRC   = 6'b010000;
  localparam logic [5:0] FL_FRAME = 6'b001000;
  localparam logic [5:0] FL_LOST  = 6'b000100;
  localparam logic [5:0] FL_BRK   = 6'b000010;
  localparam logic [5:0] FL_FWI   = 6'b000001;

  ev_t exp_q[$];
  int  n_tests = 0;
  int  n_fail  = 0;

  // Reference page bookkeeping
  logic [1:0] m_pv = 2'b00;
  logic       m_wp = 1'b0;
  logic       m_rp = 1'b0;

  function automatic ev_t mkev(input logic wr, input logic pg, input logic [7:0] a,
                               input logic [7:0] d, input logic [5:0] fl);
    ev_t e;
    e.wr = wr; e.pg = pg; e.addr = a; e.dat = d; e.fl = fl;
    return e;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_tests++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, req);
    end
  endtask

  // Monitor: every cycle the DUT shows a write or pulse, pop and compare.
  always @(negedge clk) begin
    ev_t got, e;
    if (reset_n) begin
      got = mkev(wr_en, wr_page, wr_addr, wr_data,
                 {frame_done, err_crc, err_frame, err_lost, err_break, force_wait_idle});
      if (got.wr || (got.fl != 6'b000000)) begin
        n_tests++;
        if (exp_q.size() == 0) begin
          n_fail++;
          $display("FAIL unexpected_out: got wr=%0b pg=%0b addr=%0h data=%0h fl=%b, expected nothing",
                   got.wr, got.pg, got.addr, got.dat, got.fl);
        end else begin
          e = exp_q.pop_front();
          if ((got.wr !== e.wr) || (got.fl !== e.fl) ||
              (e.wr && ((got.pg !== e.pg) || (got.addr !== e.addr) || (got.dat !== e.dat)))) begin
            n_fail++;
            $display("FAIL scoreboard_out: got wr=%0b pg=%0b addr=%0h data=%0h fl=%b, expected wr=%0b pg=%0b addr=%0h data=%0h fl=%b",
                     got.wr, got.pg, got.addr, got.dat, got.fl, e.wr, e.pg, e.addr, e.dat, e.fl);
          end
        end
      end
    end
  end

  // Verify page state against the model and that all predicted events appeared.
  task automatic check_pages(input string tag);
    check({tag, "_page_valid"}, {30'd0, page_valid}, {30'd0, m_pv});
    check({tag, "_rd_page"}, {31'd0, rd_page}, {31'd0, m_rp});
    check({tag, "_wr_page"}, {31'd0, wr_page}, {31'd0, m_wp});
    check({tag, "_pending_events"}, exp_q.size(), 32'd0);
    exp_q.delete();
  endtask

  task automatic do_release();
    @(posedge clk); #1 page_release = 1'b1;
    @(posedge clk); #1 page_release = 1'b0;
    if (m_pv[m_rp]) begin
      m_pv[m_rp] = 1'b0;
      m_rp = ~m_rp;
    end
  endtask

  // Drive one (possibly partial) frame. mode 0: bus goes idle afterwards,
  // 1: break pulse afterwards, 2: leave the line untouched (caller resets).
  task automatic run_frame(input bq_t fr, input bit crc_ok, input int mode,
                           input bit rel_at_end, input string tag);
    int         nb;
    int         len;
    int         cap;
    logic [7:0] dst;
    bit         accept, badlen, inrecv, commit, rel_ok;
    nb     = fr.size();
    dst    = (nb > 1) ? fr[1] : 8'h00;
    len    = (nb > 2) ? int'(fr[2]) : 0;
    commit = 1'b0;
    inrecv = 1'b0;

    // Frame-level prediction
    if (nb > 0) begin
      if (m_pv[m_wp]) begin
        exp_q.push_back(mkev(1'b0, 1'b0, 8'h00, 8'h00, FL_LOST));
      end else begin
        accept = promisc || (dst == filter) || (dst == 8'hff);
        badlen = (nb > 2) && (len > 253);
        cap    = (nb > 1 && !accept) ? 1 : (badlen ? 2 : 3 + len);
        for (int i = 0; i < nb && i < cap; i++)
          exp_q.push_back(mkev(1'b1, m_wp, 8'(i), fr[i], 6'b000000));
        if (nb > 1 && !accept) begin
          inrecv = 1'b0;
        end else if (badlen) begin
          exp_q.push_back(mkev(1'b0, 1'b0, 8'h00, 8'h00, FL_FRAME | FL_FWI));
        end else if (nb >= 5 + len) begin
          if (crc_ok) begin
            exp_q.push_back(mkev(1'b0, 1'b0, 8'h00, 8'h00, FL_DONE));
            commit = 1'b1;
          end else begin
            exp_q.push_back(mkev(1'b0, 1'b0, 8'h00, 8'h00, FL_CRC | FL_FWI));
          end
        end else begin
          inrecv = 1'b1;
        end
        if (inrecv && mode == 1) exp_q.push_back(mkev(1'b0, 1'b0, 8'h00, 8'h00, FL_BRK));
        if (inrecv && mode == 0) exp_q.push_back(mkev(1'b0, 1'b0, 8'h00, 8'h00, FL_FRAME));
      end
    end
    rel_ok = rel_at_end && (nb > 0) && m_pv[m_rp];
    if (rel_ok) begin
      m_pv[m_rp] = 1'b0;
      m_rp = ~m_rp;
    end
    if (commit) begin
      m_pv[m_wp] = 1'b1;
      m_wp = ~m_wp;
    end

    // Stimulus
    for (int i = 0; i < nb; i++) begin
      @(posedge clk); #1;
      data     = fr[i];
      data_clk = 1'b1;
      if (i == nb - 1 && nb == 5 + len)
        crc_data = crc_ok ? 16'h0000 : 16'($urandom_range(1, 65535));
      else
        crc_data = 16'($urandom);
      if (rel_at_end && i == nb - 1) page_release = 1'b1;
      @(posedge clk); #1;
      data_clk     = 1'b0;
      page_release = 1'b0;
    end
    if (mode == 1) begin
      @(posedge clk); #1 rx_break = 1'b1;
      @(posedge clk); #1 rx_break = 1'b0;
    end
    if (mode != 2) begin
      @(posedge clk); #1 bus_idle = 1'b1;
      repeat (3) @(posedge clk);
      #1 bus_idle = 1'b0;
      repeat (2) @(posedge clk);
      #1 check_pages(tag);
    end else begin
      repeat (2) @(posedge clk);
      #1;
    end
  endtask

  function automatic bq_t mk_frame(input logic [7:0] dst, input logic [7:0] len, input int nb);
    bq_t f;
    f.push_back(8'($urandom));
    f.push_back(dst);
    f.push_back(len);
    while (f.size() < nb) f.push_back(8'($urandom));
    while (f.size() > nb) void'(f.pop_back());
    return f;
  endfunction

  task automatic check_reset_outputs(input string tag);
    check({tag, "_wr_en"}, {31'd0, wr_en}, 32'd0);
    check({tag, "_wr_addr"}, {24'd0, wr_addr}, 32'd0);
    check({tag, "_wr_data"}, {24'd0, wr_data}, 32'd0);
    check({tag, "_pulses"},
          {26'd0, frame_done, err_crc, err_frame, err_lost, err_break, force_wait_idle}, 32'd0);
    check({tag, "_page_valid"}, {30'd0, page_valid}, 32'd0);
    check({tag, "_rd_page"}, {31'd0, rd_page}, 32'd0);
    check({tag, "_wr_page"}, {31'd0, wr_page}, 32'd0);
  endtask

  // Watchdog so the run always ends.
  initial begin
    #3000000;
    $display("FAIL watchdog: simulation still running at %0t, expected completion", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    bq_t f;
    logic [7:0] dst, len;
    int nb, mode, r;

    repeat (3) @(posedge clk);
    #1 check_reset_outputs("reset");
    reset_n = 1'b1;
    repeat (2) @(posedge clk);
    #1 bus_idle = 1'b0;
    repeat (2) @(posedge clk);

    // Good frame to page 0
    f = '{8'h01, 8'h05, 8'h02, 8'hAA, 8'hBB, 8'h00, 8'h00};
    run_frame(f, 1'b1, 0, 1'b0, "good");
    check("good_pv_const", {30'd0, page_valid}, 32'h1);

    // Filter reject, then broadcast accepted
    f = '{8'h01, 8'h07, 8'h02, 8'h11, 8'h22, 8'h00, 8'h00};
    run_frame(f, 1'b1, 0, 1'b0, "filter_reject");
    f = '{8'h02, 8'hFF, 8'h01, 8'h33, 8'h00, 8'h00};
    run_frame(f, 1'b1, 0, 1'b0, "broadcast");
    do_release();
    do_release();

    // CRC error and length errors / length boundaries
    run_frame(mk_frame(8'h05, 8'd3, 8), 1'b0, 0, 1'b0, "crc_err");
    run_frame(mk_frame(8'h05, 8'hFE, 6), 1'b1, 0, 1'b0, "len_fe");
    run_frame(mk_frame(8'h05, 8'd254, 6), 1'b1, 0, 1'b0, "len_254");
    run_frame(mk_frame(8'h05, 8'd253, 258), 1'b1, 0, 1'b0, "len_253");
    run_frame(mk_frame(8'h05, 8'd0, 5), 1'b1, 0, 1'b0, "len_0");

    // Page full then release
    run_frame(mk_frame(8'h05, 8'd2, 7), 1'b1, 0, 1'b0, "fill_a");
    run_frame(mk_frame(8'h05, 8'd2, 7), 1'b1, 0, 1'b0, "fill_b");
    run_frame(mk_frame(8'h05, 8'd2, 7), 1'b1, 0, 1'b0, "lost");
    do_release();
    #1 check_pages("release_one");
    run_frame(mk_frame(8'h05, 8'd1, 6), 1'b1, 0, 1'b0, "after_release");
    do_release();
    #1 check_pages("release_two");

    // Commit and release in the same cycle
    run_frame(mk_frame(8'h05, 8'd2, 7), 1'b1, 0, 1'b1, "simul");
    check("simul_pv_const", {30'd0, page_valid}, 32'h2);
    check("simul_rp_const", {31'd0, rd_page}, 32'h1);

    // Break and truncation
    run_frame(mk_frame(8'h05, 8'd4, 4), 1'b1, 1, 1'b0, "break");
    run_frame(mk_frame(8'h05, 8'd4, 3), 1'b1, 0, 1'b0, "truncate");

    // Release when nothing is valid is ignored
    do_release();
    do_release();
    #1 check_pages("idle_release");

    // Randomized frames
    for (int k = 0; k < 40; k++) begin
      r = int'($urandom_range(0, 3));
      dst = (r == 1) ? 8'hFF : ((r == 2) ? 8'($urandom) : filter);
      promisc = ($urandom_range(0, 3) == 0);
      len = ($urandom_range(0, 7) == 0) ? 8'($urandom_range(0, 255)) : 8'($urandom_range(0, 12));
      mode = int'($urandom_range(0, 4));
      if (mode <= 1) nb = int'($urandom_range(1, 4 + int'(len)));
      else           nb = (len > 8'd253) ? 6 : 5 + int'(len);
      if ($urandom_range(0, 1) == 1) do_release();
      run_frame(mk_frame(dst, len, nb), ($urandom_range(0, 3) != 0), (mode == 1) ? 1 : 0,
                ($urandom_range(0, 5) == 0), "rand");
    end
    promisc = 1'b0;

    // Reset in the middle of a frame
    while (m_pv != 2'b00) do_release();
    run_frame(mk_frame(8'h05, 8'd6, 3), 1'b1, 2, 1'b0, "pre_reset");
    check("pre_reset_events", exp_q.size(), 32'd0);
    reset_n = 1'b0;
    bus_idle = 1'b1;
    #1 check_reset_outputs("mid_reset");
    exp_q.delete();
    m_pv = 2'b00; m_wp = 1'b0; m_rp = 1'b0;
    @(posedge clk); #1 reset_n = 1'b1;
    repeat (2) @(posedge clk);
    #1 bus_idle = 1'b0;
    run_frame(mk_frame(8'h05, 8'd2, 7), 1'b1, 0, 1'b0, "post_reset");

    check("final_queue_empty", exp_q.size(), 32'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
